led_pattern_ctrl: RTL

Front-panel controller for the LED board. Two raw push-buttons are synchronised and debounced, then reduced to one-cycle rising-edge pulses. One button selects the LED pattern mode; the other selects the step speed. A prescaled step scheduler advances the pattern on an NUM_LEDS-wide LED bus. It sits between the board pins and the LED outputs and is the only owner of the LED register.

---
 rtl/led_pattern_ctrl_pkg.sv | 29 ++
 rtl/led_pattern_ctrl_deb.sv | 41 ++++
 rtl/led_pattern_ctrl.sv | 100 ++++++++++
 3 files changed

// File: rtl/led_pattern_ctrl_pkg.sv
// Shared constants and seed patterns for the LED front-panel controller.
package led_pattern_ctrl_pkg;

  localparam int SPD_W = 2;

  localparam logic [1:0] MODE_OFF   = 2'd0;
  localparam logic [1:0] MODE_SHL   = 2'd1;
  localparam logic [1:0] MODE_SHR   = 2'd2;
  localparam logic [1:0] MODE_BLINK = 2'd3;

  // Bit i of the seed pattern for mode m on an n-wide LED bus.
  function automatic logic seed_bit(
    input logic [1:0] m,
    input int         n,
    input int         i
  );
    logic b;
    b = 1'b0;
    unique case (m)
      MODE_OFF:   b = 1'b0;
      MODE_SHL:   b = (i == 0);
      MODE_SHR:   b = (i == n - 1);
      MODE_BLINK: b = 1'b1;
      default:    b = 1'b0;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/led_pattern_ctrl_deb.sv
// Button synchroniser, debouncer and rising-edge pulse generator.
module btn_deb_edge #(
  parameter int DEB_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic level,
  output logic rise
);

  localparam int CW = (DEB_CYCLES > 0) ? $clog2(DEB_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CMAX = CW'(DEB_CYCLES);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
    end else begin
      s1   <= in;
      s2   <= s1;
      rise <= 1'b0;
      if (s1 != s2)
        cnt <= '0;
      else if (cnt != CMAX)
        cnt <= cnt + CW'(1);
      if (cnt == CMAX) begin
        level <= s2;
        rise  <= s2 & ~level;
      end
    end
  end

endmodule

// File: rtl/led_pattern_ctrl.sv
// LED pattern controller: mode/speed buttons, step scheduler, LED register.
module led_pattern_ctrl
  import led_pattern_ctrl_pkg::*;
#(
  parameter int NUM_LEDS   = 8,
  parameter int DEB_CYCLES = 255,
  parameter int TICK_DIV   = 1000000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                btn_mode,
  input  logic                btn_speed,
  output logic [NUM_LEDS-1:0] led,
  output logic [1:0]          mode,
  output logic [SPD_W-1:0]    speed,
  output logic                step
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

  logic                mode_ev;
  logic                speed_ev;
  logic [PW-1:0]       presc;
  logic [SPD_W-1:0]    scnt;
  logic                tick;
  logic                step_now;
  logic [1:0]          mode_nx;
  logic [NUM_LEDS-1:0] seed;
  logic [NUM_LEDS-1:0] led_step;

  btn_deb_edge #(.DEB_CYCLES(DEB_CYCLES)) u_mode (
    .clk   (clk),
    .rst   (rst),
    .in    (btn_mode),
    .level (),
    .rise  (mode_ev)
  );

  btn_deb_edge #(.DEB_CYCLES(DEB_CYCLES)) u_speed (
    .clk   (clk),
    .rst   (rst),
    .in    (btn_speed),
    .level (),
    .rise  (speed_ev)
  );

  assign tick     = (presc == PMAX);
  assign step_now = tick && (scnt == speed);
  assign mode_nx  = mode + 2'd1;

  always_comb begin
    seed = '0;
    for (int i = 0; i < NUM_LEDS; i++)
      seed[i] = seed_bit(mode_nx, NUM_LEDS, i);
  end

  always_comb begin
    led_step = led;
    unique case (mode)
      MODE_SHL:   led_step = {led[NUM_LEDS-2:0], led[NUM_LEDS-1]};
      MODE_SHR:   led_step = {led[0], led[NUM_LEDS-1:1]};
      MODE_BLINK: led_step = ~led;
      default:    led_step = led;
    endcase
  end

  // A mode change reseeds and restarts the schedule, swallowing any step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led   <= '0;
      mode  <= MODE_OFF;
      speed <= '0;
      step  <= 1'b0;
      presc <= '0;
      scnt  <= '0;
    end else begin
      step <= 1'b0;
      if (speed_ev)
        speed <= speed + SPD_W'(1);
      if (mode_ev) begin
        mode  <= mode_nx;
        led   <= seed;
        presc <= '0;
        scnt  <= '0;
      end else begin
        presc <= tick ? '0 : presc + PW'(1);
        if (step_now) begin
          step <= 1'b1;
          led  <= led_step;
        end
        if (speed_ev || step_now)
          scnt <= '0;
        else if (tick)
          scnt <= scnt + SPD_W'(1);
      end
    end
  end

endmodule
